// File: rtl/block_cla_subtractor_seq.sv
// Block-serial unsigned subtractor D = X - Y. One block carry look-ahead
// block is resolved per clock; the block carry is kept in a register.
module block_cla_subtractor_seq #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned BLOCK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   D
);

  localparam int unsigned NB   = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int unsigned NPAD = NB * BLOCK;
  localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_ready_nxt;
  logic              out_valid_nxt;

  logic [WIDTH-1:0]  xr;
  logic [WIDTH-1:0]  yr;
  logic              cr;
  logic [IW-1:0]     idx;
  logic              last;

  logic [NPAD-1:0]   xpad;
  logic [NPAD-1:0]   ypad;
  logic [NPAD-1:0]   spad;
  logic [BLOCK-1:0]  g;
  logic [BLOCK-1:0]  p;
  logic [BLOCK-1:0]  s;
  logic [BLOCK:0]    c;
  logic              prod;
  logic              gb;
  logic              pb;
  logic              cb;
  logic [WIDTH:0]    d_nxt;

  assign last = (idx == IW'(NB - 1));

  // Select the current block of X and ~Y; bits beyond WIDTH are carry-transparent.
  always_comb begin
    g    = '0;
    p    = '1;
    xpad = NPAD'(xr);
    ypad = NPAD'(yr);
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned i = 0; i < BLOCK; i++) begin
        if ((idx == IW'(b)) && ((b * BLOCK + i) < WIDTH)) begin
          g[i] = xpad[b * BLOCK + i] & ~ypad[b * BLOCK + i];
          p[i] = xpad[b * BLOCK + i] ^ ~ypad[b * BLOCK + i];
        end
      end
    end
  end

  // Look-ahead carries, sum bits and group generate/propagate of the block.
  always_comb begin
    c    = '0;
    c[0] = cr;
    prod = 1'b0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & cr);
    end
    s    = p ^ c[BLOCK-1:0];
    gb   = g[BLOCK-1];
    prod = p[BLOCK-1];
    for (int j = int'(BLOCK) - 2; j >= 0; j--) begin
      gb   = gb | (prod & g[j]);
      prod = prod & p[j];
    end
    pb = &p;
    cb = gb | (pb & cr);
  end

  // Merge the resolved block into the result; the final block also sets the borrow.
  always_comb begin
    spad = NPAD'(D[WIDTH-1:0]);
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned i = 0; i < BLOCK; i++) begin
        if ((idx == IW'(b)) && ((b * BLOCK + i) < WIDTH)) begin
          spad[b * BLOCK + i] = s[i];
        end
      end
    end
    d_nxt = {(last ? ~cb : D[WIDTH]), spad[WIDTH-1:0]};
  end

  // State register with registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      IN_READY  <= in_ready_nxt;
      OUT_VALID <= out_valid_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (RST) state_nxt = IDLE;
  end

  // Handshake outputs depend only on the upcoming state.
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    if (state_nxt == IDLE) in_ready_nxt = 1'b1;
    if (state_nxt == DONE) out_valid_nxt = 1'b1;
  end

  // Operand capture and block-serial datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xr  <= '0;
      yr  <= '0;
      cr  <= 1'b1;
      idx <= '0;
      D   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            xr  <= X;
            yr  <= Y;
            cr  <= 1'b1;
            idx <= '0;
          end
        end
        BUSY: begin
          D   <= d_nxt;
          cr  <= cb;
          idx <= last ? '0 : idx + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_cla_subtractor_seq.sv
// Self-checking bench for block_cla_subtractor_seq: latency/handshake model plus result scoreboard.
module tb_block_cla_subtractor_seq;

  localparam int WIDTH = 11;
  localparam int NB    = 3;
  localparam int NRAND = 2000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   d;

  int tests;
  int fails;
  bit chk_en;

  // reference model state
  int m_cnt;
  bit m_valid;
  int q[$];
  int n_in;
  int n_out;

  block_cla_subtractor_seq dut (
    .CLK      (clk),
    .RST      (rst),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .X        (x),
    .Y        (y),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .D        (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int diff_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int e;
    e = int'(a) - int'(b);
    if (e < 0) e += 4096;
    return e;
  endfunction

  // Behavioural model: NB cycles of work after accept, then hold until consumed.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      q.delete();
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        void'(q.pop_front());
        n_out++;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1'b1;
    end else if (in_valid) begin
      q.push_back(diff_mod(x, y));
      m_cnt = NB;
      n_in++;
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(m_cnt == 0 && !m_valid));
      check("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid && q.size() > 0) check("d_model", int'(d), q[0]);
    end
  end

  // Wait (from a negedge) for OUT_VALID, counting rising edges.
  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for OUT_VALID", name);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for IN_READY", name);
    end
  endtask

  // Single operation with OUT_READY high; checks latency, literal result and ready return.
  task automatic do_op(input string name, input int xv, input int yv, input int exp);
    int cyc;
    wait_ready(name);
    in_valid  = 1'b1;
    x         = WIDTH'(xv);
    y         = WIDTH'(yv);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(name, cyc);
    check({name, "_latency"}, cyc, NB);
    check({name, "_d"}, int'(d), exp);
    @(negedge clk);
    check({name, "_ready_back"}, int'(in_ready), 1);
    check({name, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int in0;
    int out0;
    int n;
    tests     = 0;
    fails     = 0;
    chk_en    = 1'b0;
    n_in      = 0;
    n_out     = 0;
    m_cnt     = 0;
    m_valid   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state after three idle cycles
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_d", int'(d), 0);

    // Directed results, hand-computed
    do_op("sub_1000_1", 1000, 1, 'h3E7);
    do_op("sub_0_1", 0, 1, 'hFFF);
    do_op("sub_400_1", 'h400, 'h001, 'h3FF);
    do_op("sub_7ff_7ff", 'h7FF, 'h7FF, 'h000);
    do_op("sub_0_7ff", 0, 'h7FF, 'h801);

    // Backpressure: hold DONE while 9/1 is presented
    wait_ready("bp");
    in_valid  = 1'b1;
    x         = WIDTH'(5);
    y         = WIDTH'(3);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    x = WIDTH'(9);
    y = WIDTH'(1);
    wait_valid("bp", cyc);
    for (int i = 0; i < 6; i++) begin
      check("bp_d_hold", int'(d), 'h002);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_valid_hold", int'(out_valid), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_after_hs", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("bp2", cyc);
    check("bp2_latency", cyc, NB);
    check("bp2_d", int'(d), 'h008);
    @(negedge clk);

    // Reset during BUSY with IDX=1
    wait_ready("rst_mid");
    in_valid  = 1'b1;
    x         = WIDTH'(100);
    y         = WIDTH'(50);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_out_valid", int'(out_valid), 0);
    do_op("sub_7_2", 7, 2, 'h005);

    // Random regression with random gaps and backpressure
    in0  = n_in;
    out0 = n_out;
    n    = 0;
    while ((n_in - in0) < NRAND && n < 50000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       x = '0;
        1:       x = '1;
        default: x = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       y = '1;
        default: y = WIDTH'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || m_cnt != 0 || m_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rand_accepted", n_in - in0, NRAND);
    check("rand_delivered", n_out - out0, n_in - in0);
    check("rand_queue_empty", q.size(), 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
